// File: rtl/d_latch_pkg.sv
// Shared constants and helpers for the d_latch transparent-high latch and its
// optional capture counter (enabled with D_LATCH_CAPTURE_CNT_EN).
package d_latch_pkg;

  localparam int D_LATCH_WIDTH_DEF = 1;
  localparam int D_LATCH_CNT_W     = 16;
  localparam logic [D_LATCH_CNT_W-1:0] D_LATCH_CNT_MAX = {D_LATCH_CNT_W{1'b1}};

  // Counter increment that sticks at the maximum instead of wrapping.
  function automatic logic [D_LATCH_CNT_W-1:0] cnt_sat_inc(input logic [D_LATCH_CNT_W-1:0] c);
    if (c == D_LATCH_CNT_MAX) begin
      return c;
    end else begin
      return c + D_LATCH_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/d_latch_cap_cnt.sv
// Change detector plus saturating counter, clocked on the closing (falling)
// clk edge; only built when D_LATCH_CAPTURE_CNT_EN is defined.
module d_latch_cap_cnt
  import d_latch_pkg::*;
#(
  parameter int               WIDTH     = D_LATCH_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         close_val,
  output logic [D_LATCH_CNT_W-1:0] cnt
);

  logic [WIDTH-1:0]         prev_d, prev_q;
  logic [D_LATCH_CNT_W-1:0] cnt_d, cnt_q;

  // Next state: remember the value just closed, count it if it changed.
  always_comb begin
    prev_d = close_val;
    cnt_d  = cnt_q;
    if (close_val != prev_q) begin
      cnt_d = cnt_sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The latch output is still the pre-edge value at the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/d_latch.sv
// WIDTH-bit transparent-high D latch with async active-low reset, q_n and hold.
// Define D_LATCH_CAPTURE_CNT_EN to add the cap_cnt closed-value change counter.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int               WIDTH     = D_LATCH_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         D,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_n,
`ifdef D_LATCH_CAPTURE_CNT_EN
  output logic                     hold,
  output logic [D_LATCH_CNT_W-1:0] cap_cnt
`else
  output logic                     hold
`endif
);

  logic [WIDTH-1:0] q_lat;

  // Intentional latch: reset wins, clk high is transparent, clk low holds.
  always_latch begin
    if (!rst_n) begin
      q_lat <= RESET_VAL;
    end else if (clk) begin
      q_lat <= D;
    end
  end

  assign q    = q_lat;
  assign q_n  = ~q_lat;
  assign hold = rst_n & ~clk;

`ifdef D_LATCH_CAPTURE_CNT_EN
  d_latch_cap_cnt #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_cap_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .close_val (q_lat),
    .cnt       (cap_cnt)
  );
`endif

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch: timed directed scenarios plus randomized
// phases checked against a per-phase latch model.
`timescale 1ns/1ps
module tb_d_latch;
  import d_latch_pkg::*;

  localparam int         W  = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] D;
  logic [W-1:0] q, q_n;
  logic         hold;
`ifdef D_LATCH_CAPTURE_CNT_EN
  logic [D_LATCH_CNT_W-1:0] cap_cnt;
`endif

  int errors = 0;
  int checks = 0;

  d_latch #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .q       (q),
    .q_n     (q_n),
`ifdef D_LATCH_CAPTURE_CNT_EN
    .hold    (hold),
    .cap_cnt (cap_cnt)
`else
    .hold    (hold)
`endif
  );

  always #5 clk = ~clk;

  task automatic wait_until(input int t);
    if ($time < t) #(t - $time);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; D = 8'h01;
    wait_until(1);
    checks++; if (q !== RV) begin errors++; $display("FAIL rst_q act=%h exp=%h", q, RV); end
    checks++; if (q_n !== ~RV) begin errors++; $display("FAIL rst_qn act=%h exp=%h", q_n, ~RV); end
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL rst_hold act=%b exp=0", hold); end
    wait_until(2); rst_n = 1'b1;
    wait_until(3);
    checks++; if (q !== RV) begin errors++; $display("FAIL rel_low_q act=%h exp=%h", q, RV); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rel_low_hold act=%b exp=1", hold); end
    wait_until(6);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL first_open_q act=%h exp=01", q); end
    checks++; if (q_n !== 8'hFE) begin errors++; $display("FAIL first_open_qn act=%h exp=fe", q_n); end
    wait_until(7); rst_n = 1'b0;
    wait_until(8);
    checks++; if (q !== RV) begin errors++; $display("FAIL rst_dominates act=%h exp=%h", q, RV); end
    rst_n = 1'b1;
    wait_until(9);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL rel_high_q act=%h exp=01", q); end
  endtask

  task automatic test_transparency;
    wait_until(12); D = 8'h00;
    wait_until(13);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL opaque_ign act=%h exp=01", q); end
    wait_until(17);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rise_take0 act=%h exp=00", q); end
    wait_until(22); D = 8'h01;
    wait_until(24);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL pre_rise act=%h exp=00", q); end
    wait_until(27);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL rise_take1 act=%h exp=01", q); end
  endtask

  task automatic test_hold;
    wait_until(31); D = 8'h00;
    wait_until(32); D = 8'h01;
    wait_until(33); D = 8'h00;
    wait_until(34);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL hold_q act=%h exp=01", q); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL hold_flag act=%b exp=1", hold); end
    wait_until(37);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL hold_rise act=%h exp=00", q); end
  endtask

  task automatic test_coincident_edge;
    @(negedge clk); D = 8'h01;
    wait_until(42);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL coinc_pre act=%h exp=00", q); end
    wait_until(47);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL coinc_post act=%h exp=01", q); end
  endtask

  task automatic test_mid_hold_reset;
    wait_until(51); rst_n = 1'b0;
    wait_until(52);
    checks++; if (q !== RV) begin errors++; $display("FAIL midrst_q act=%h exp=%h", q, RV); end
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL midrst_hold act=%b exp=0", hold); end
    rst_n = 1'b1;
    wait_until(53);
    checks++; if (q !== RV) begin errors++; $display("FAIL midrst_lost act=%h exp=%h", q, RV); end
    wait_until(57);
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL midrst_rise act=%h exp=01", q); end
    D = 8'h3C;
    wait_until(58);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL transp_follow act=%h exp=3c", q); end
  endtask

`ifdef D_LATCH_CAPTURE_CNT_EN
  task automatic test_cap_cnt;
    logic [W-1:0]             vals [5];
    logic [D_LATCH_CNT_W-1:0] exps [5];
    vals = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    exps = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3};
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    checks++; if (cap_cnt !== 16'd0) begin errors++; $display("FAIL cnt_rst act=%0d exp=0", cap_cnt); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 D = vals[i];
      @(negedge clk); #1;
      checks++; if (cap_cnt !== exps[i]) begin errors++; $display("FAIL cnt_seq%0d act=%0d exp=%0d", i, cap_cnt, exps[i]); end
    end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0]             m_q, m_prev;
    logic [D_LATCH_CNT_W-1:0] m_cnt;
    @(negedge clk); #1;
    rst_n = 1'b0; #1 rst_n = 1'b1;
    m_q = RV; m_prev = RV; m_cnt = '0;
    for (int n = 0; n < 200; n++) begin
      // Low phase: optional reset pulse, then D wiggles that must be ignored.
      if ($urandom_range(15) == 0) begin
        rst_n = 1'b0; #1;
        checks++; if (q !== RV) begin errors++; $display("FAIL rnd_rst act=%h exp=%h", q, RV); end
        rst_n = 1'b1;
        m_q = RV; m_prev = RV; m_cnt = '0;
      end else begin
        #1;
      end
      D = W'($urandom); #1;
      checks++; if (q !== m_q || hold !== 1'b1) begin errors++; $display("FAIL rnd_low1 act=%h/%b exp=%h/1", q, hold, m_q); end
      D = W'($urandom); #1;
      checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_low2 act=%h exp=%h", q, m_q); end
      // High phase: output tracks D as soon as the gate opens and on every change.
      @(posedge clk); #1;
      m_q = D;
      checks++; if (q !== m_q || hold !== 1'b0) begin errors++; $display("FAIL rnd_open act=%h/%b exp=%h/0", q, hold, m_q); end
      D = W'($urandom); m_q = D; #1;
      checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_hi1 act=%h exp=%h", q, m_q); end
      D = W'($urandom); m_q = D; #1;
      checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_hi2 act=%h exp=%h", q, m_q); end
      @(negedge clk);
      if (m_q != m_prev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_prev = m_q;
      #1;
      checks++; if (q !== m_q || q_n !== ~m_q) begin errors++; $display("FAIL rnd_close act=%h/%h exp=%h/%h", q, q_n, m_q, ~m_q); end
`ifdef D_LATCH_CAPTURE_CNT_EN
      checks++; if (cap_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt act=%0d exp=%0d", cap_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_transparency;
    test_hold;
    test_coincident_edge;
    test_mid_hold_reset;
`ifdef D_LATCH_CAPTURE_CNT_EN
    test_cap_cnt;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
